// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - assembles consecutive UART bytes MSB-first into one word
// Frames are aborted when the gap between bytes exceeds TIMEOUT_CYCLES.
module frame_reader #(
  parameter int UART_BUS_SIZE    = 8,
  parameter int DATA_IN_BUS_SIZE = 32,
  parameter int TIMEOUT_CYCLES   = 50000
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start_rd,
  input  logic                        i_rx_done,
  input  logic [UART_BUS_SIZE-1:0]    i_rx_data,
  output logic [DATA_IN_BUS_SIZE-1:0] o_data_rd,
  output logic                        o_rd_end,
  output logic                        o_timeout,
  output logic                        o_busy
);

  localparam int  BYTES   = DATA_IN_BUS_SIZE / UART_BUS_SIZE;
  localparam int  CNT_W   = $clog2(BYTES) + 1;
  localparam int  TO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit  TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int  TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [DATA_IN_BUS_SIZE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]            byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
  logic [DATA_IN_BUS_SIZE-1:0] data_q, data_d;
  logic                        rd_end_q, rd_end_d;
  logic                        timeout_q, timeout_d;
  logic                        busy_q, busy_d;

  // Shifting the full register also covers the single-byte word case,
  // where the shift drops every old bit and only the new byte remains.
  logic [DATA_IN_BUS_SIZE-1:0] shift_in;
  logic                        last_byte;
  logic                        to_expired;

  assign shift_in   = (shift_q << UART_BUS_SIZE) | DATA_IN_BUS_SIZE'(i_rx_data);
  assign last_byte  = (byte_cnt_q == CNT_W'(BYTES - 1));
  assign to_expired = (to_cnt_q == TO_W'(TO_LAST));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = to_cnt_q;
    data_d     = data_q;
    rd_end_d   = 1'b0;
    timeout_d  = 1'b0;
    busy_d     = busy_q;
    unique case (state_q)
      IDLE: begin
        if (i_start_rd) begin
          state_d    = RECEIVE;
          shift_d    = '0;
          byte_cnt_d = '0;
          to_cnt_d   = '0;
          busy_d     = 1'b1;
        end
      end
      RECEIVE: begin
        // A strobe takes priority over an expiring timeout in the same cycle.
        if (i_rx_done) begin
          shift_d    = shift_in;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          to_cnt_d   = '0;
          if (last_byte) begin
            data_d   = shift_in;
            rd_end_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end else if (TO_EN) begin
          if (to_expired) begin
            timeout_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      data_q     <= '0;
      rd_end_q   <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      data_q     <= data_d;
      rd_end_q   <= rd_end_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
    end
  end

  assign o_data_rd = data_q;
  assign o_rd_end  = rd_end_q;
  assign o_timeout = timeout_q;
  assign o_busy    = busy_q;

endmodule
